spi_flash_reader: RTL
=====================

SPI_FLASH_READER -- requirements
Module: spi_flash_reader

Interface
REQ-001 Parameter CLK_DIV, default 2, SCK half-period in i_CLK cycles (legal 1..255).
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 i_CLK  in  1  system clock, all state on rising edge.
REQ-004 i_RST_N  in  1  asynchronous active-low reset.
REQ-005 i_REQ  in  1  start read; sampled only in IDLE.
REQ-006 i_ADDR  in  24  flash byte address, captured with i_REQ.
REQ-007 i_LEN  in  8  byte count, 0 encodes 256, captured with i_REQ.
REQ-008 i_FT_CS  in  1  FT2232 chip select, low = FT2232 owns flash bus.
REQ-009 o_BUSY  out  1  high from accept through end of HOLD.
REQ-010 o_DATA  out  8  received byte, held until next o_DATA_VALID.
REQ-011 o_DATA_VALID  out  1  one-cycle strobe per received byte.
REQ-012 o_DONE  out  1  one-cycle strobe, all i_LEN bytes delivered.
REQ-013 o_ABORT  out  1  one-cycle strobe, transfer cut short by FT2232.
REQ-014 o_SPI_CS  out  1  flash chip select, active low.
REQ-015 o_SPI_CLK  out  1  flash SCK, SPI mode 0, idles low.
REQ-016 o_SPI_MOSI  out  1  flash data in, MSB first.
REQ-017 i_SPI_MISO  in  1  flash data out.

Function
REQ-018 States: IDLE, SETUP, CMDADDR, DATA, HOLD.
REQ-019 IDLE -> SETUP when i_REQ=1 and i_FT_CS=1; i_REQ with i_FT_CS=0 is ignored (no strobe, o_BUSY stays 0).
REQ-020 Accept cycle registers i_ADDR, i_LEN; o_SPI_CS=0 and o_BUSY=1 on next cycle.
REQ-021 SETUP lasts CLK_DIV cycles with SCK low and MOSI = bit 31 of shift word, then -> CMDADDR.
REQ-022 Shift word = {8'h03, addr[23:0]}, 32 bits, MSB first.
REQ-023 SCK toggles every CLK_DIV cycles; MOSI updates only on SCK falling edge; MISO sampled on the i_CLK edge that raises SCK.
REQ-024 CMDADDR -> DATA after 32nd SCK falling edge; DATA shifts MISO into an 8-bit register MSB first.
REQ-025 o_DATA updates and o_DATA_VALID pulses on the cycle after the 8th rising edge of each byte.
REQ-026 Byte counter is 9 bits, loaded 256 when i_LEN=0, decremented per byte; at 0 after final falling edge -> HOLD.
REQ-027 HOLD: SCK low, CS held low CLK_DIV cycles, then CS=1, o_DONE pulse, -> IDLE with o_BUSY=0 same cycle as o_DONE.
REQ-028 Address wrap beyond 24'hFFFFFF is the flash's concern; block issues no extra command.
REQ-029 i_FT_CS falling in any non-IDLE state: next cycle CS=1, SCK=0, MOSI=0, o_ABORT pulse, o_BUSY=0, -> IDLE; no o_DONE, no partial-byte o_DATA_VALID.
REQ-030 i_REQ while o_BUSY=1 is ignored.
REQ-031 o_SPI_MOSI drives 0 whenever CS=1.

Reset
REQ-032 During i_RST_N=0: state IDLE, o_SPI_CS=1, o_SPI_CLK=0, o_SPI_MOSI=0, o_BUSY=0, o_DATA=8'h00, all strobes 0, counters 0.
REQ-033 Reset asserted mid-transfer ends it immediately with the above values and no o_DONE or o_ABORT.
REQ-034 First i_REQ accepted no earlier than first clock edge after i_RST_N deasserts.

Structure
REQ-035 Shared package spi_flash_pkg holds CMD_READ=8'h03, ADDR_W=24, state encodings.
REQ-036 One sub-module spi_sck_gen: CLK_DIV counter producing sck level plus rise/fall strobes, enabled only in SETUP..HOLD.

Verification
REQ-037 CLK_DIV=2, ADDR=24'h012345, LEN=1, flash model returns 8'hA5 -> MOSI stream 03 01 23 45, o_DATA=8'hA5 with one VALID, o_DONE once, 40 SCK rising edges.
REQ-038 LEN=0 from ADDR=24'hFFFF00 -> exactly 256 VALID strobes, data matches model, one o_DONE.
REQ-039 i_FT_CS low during byte 3 of LEN=4 -> CS=1 next cycle, o_ABORT once, 2 VALID strobes total, no o_DONE.
REQ-040 i_REQ with i_FT_CS=0 -> CS stays 1, o_BUSY stays 0, no strobes; second i_REQ during busy ignored.
REQ-041 i_RST_N low mid-CMDADDR -> outputs at reset values asynchronously, later LEN=1 request completes normally.
REQ-042 CLK_DIV=1 and CLK_DIV=5, LEN=2 -> SCK period 2 and 10 i_CLK, correct bytes received.

Source files
------------

// File: rtl/spi_flash_reader_pkg.sv
// spi_flash_pkg: shared constants and FSM state encoding for the SPI flash reader.
// No ports; imported by the interface, the SCK generator's user and the top.
package spi_flash_pkg;
    localparam logic [7:0] CMD_READ = 8'h03;
    localparam int         ADDR_W   = 24;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_CMDADDR,
        ST_DATA,
        ST_HOLD
    } state_t;
endpackage

// File: rtl/spi_flash_reader_if.sv
// spi_flash_reader_if: request/response handshake plus SPI flash pins.
// Ports (slave view): i_REQ/i_ADDR/i_LEN start a read, i_FT_CS is the FT2232
// bus claim, i_SPI_MISO is flash data; o_BUSY/o_DATA/o_DATA_VALID/o_DONE/o_ABORT
// report progress, o_SPI_CS/o_SPI_CLK/o_SPI_MOSI drive the flash.
interface spi_flash_reader_if;
    import spi_flash_pkg::*;
    logic              i_REQ;
    logic [ADDR_W-1:0] i_ADDR;
    logic [7:0]        i_LEN;
    logic              i_FT_CS;
    logic              o_BUSY;
    logic [7:0]        o_DATA;
    logic              o_DATA_VALID;
    logic              o_DONE;
    logic              o_ABORT;
    logic              o_SPI_CS;
    logic              o_SPI_CLK;
    logic              o_SPI_MOSI;
    logic              i_SPI_MISO;
    modport slave (
        input  i_REQ, i_ADDR, i_LEN, i_FT_CS, i_SPI_MISO,
        output o_BUSY, o_DATA, o_DATA_VALID, o_DONE, o_ABORT, o_SPI_CS, o_SPI_CLK, o_SPI_MOSI
    );
    modport master (
        output i_REQ, i_ADDR, i_LEN, i_FT_CS, i_SPI_MISO,
        input  o_BUSY, o_DATA, o_DATA_VALID, o_DONE, o_ABORT, o_SPI_CS, o_SPI_CLK, o_SPI_MOSI
    );
endinterface

// File: rtl/spi_flash_reader_sck_gen.sv
// spi_sck_gen: CLK_DIV half-period counter producing SCK level and edge strobes.
// Ports: clk, rst_n (async active-low); en_i runs the counter (cleared when low),
// tgl_i lets SCK toggle on each tick; sck_o level, tick_o end of half-period,
// rise_o/fall_o flag the cycle whose closing edge raises/lowers SCK.
module spi_sck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic tgl_i,
    output logic sck_o,
    output logic tick_o,
    output logic rise_o,
    output logic fall_o
);
    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);
    logic [7:0] cnt_q, cnt_d;
    logic       sck_q, sck_d;
    assign tick_o = en_i && (cnt_q == LAST);
    assign rise_o = tick_o && tgl_i && !sck_q;
    assign fall_o = tick_o && tgl_i && sck_q;
    // Gating with en_i forces SCK low in the very cycle the transfer stops.
    assign sck_o  = en_i && sck_q;
    always_comb begin
        cnt_d = (en_i && !tick_o) ? cnt_q + 8'd1 : 8'd0;
        sck_d = en_i && (sck_q ^ (tick_o && tgl_i));
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end
endmodule

// File: rtl/spi_flash_reader.sv
// spi_flash_reader: issues a 0x03 READ with 24-bit address and streams i_LEN bytes
// (0 = 256) back as o_DATA/o_DATA_VALID, yielding the bus whenever the FT2232 claims it.
// Ports: i_CLK, i_RST_N (async active-low), bus = spi_flash_reader_if.slave.
module spi_flash_reader
    import spi_flash_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic              i_CLK,
    input  logic              i_RST_N,
    spi_flash_reader_if.slave bus
);
    state_t      state_q, state_d;
    logic [31:0] shift_q, shift_d;
    logic [6:0]  rx_q, rx_d;
    logic [7:0]  data_q, data_d;
    logic [4:0]  bit_q, bit_d;
    logic [8:0]  byte_q, byte_d;
    logic        valid_q, valid_d, done_q, done_d, abort_q, abort_d;
    logic        sck, tick, rise, fall;
    spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
        .clk    (i_CLK),
        .rst_n  (i_RST_N),
        .en_i   (state_q != ST_IDLE),
        .tgl_i  (state_q != ST_HOLD),
        .sck_o  (sck),
        .tick_o (tick),
        .rise_o (rise),
        .fall_o (fall)
    );
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        rx_d    = rx_q;
        data_d  = data_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        abort_d = 1'b0;
        if (state_q == ST_IDLE) begin
            if (bus.i_REQ && bus.i_FT_CS) begin
                state_d = ST_SETUP;
                shift_d = {CMD_READ, bus.i_ADDR};
                byte_d  = (bus.i_LEN == 8'd0) ? 9'd256 : {1'b0, bus.i_LEN};
                bit_d   = '0;
            end
        end else if (!bus.i_FT_CS) begin
            // FT2232 took the bus: drop everything, including any partial byte.
            state_d = ST_IDLE;
            abort_d = 1'b1;
            shift_d = '0;
            rx_d    = '0;
            bit_d   = '0;
            byte_d  = '0;
        end else begin
            case (state_q)
                ST_SETUP: state_d = rise ? ST_CMDADDR : ST_SETUP;
                ST_CMDADDR: begin
                    if (fall) begin
                        // Shifting in zeros leaves MOSI low once the header is out.
                        shift_d = shift_q << 1;
                        bit_d   = bit_q + 5'd1;
                        state_d = (bit_q == 5'd31) ? ST_DATA : ST_CMDADDR;
                    end
                end
                ST_DATA: begin
                    if (rise) begin
                        rx_d  = {rx_q[5:0], bus.i_SPI_MISO};
                        bit_d = bit_q + 5'd1;
                        if (bit_q[2:0] == 3'd7) begin
                            data_d  = {rx_q, bus.i_SPI_MISO};
                            valid_d = 1'b1;
                            byte_d  = byte_q - 9'd1;
                        end
                    end else if (fall && byte_q == 9'd0) begin
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        bit_d   = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            rx_q    <= '0;
            data_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            rx_q    <= rx_d;
            data_q  <= data_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end
    assign bus.o_BUSY       = state_q != ST_IDLE;
    assign bus.o_SPI_CS     = state_q == ST_IDLE;
    assign bus.o_SPI_CLK    = sck;
    assign bus.o_SPI_MOSI   = shift_q[31];
    assign bus.o_DATA       = data_q;
    assign bus.o_DATA_VALID = valid_q;
    assign bus.o_DONE       = done_q;
    assign bus.o_ABORT      = abort_q;
endmodule
